alu_port_scheduler: RTL and testbench

//  Four-port issue scheduler in front of the shared ALU. Buffers one command per port and picks one per cycle
//  (round-robin). Drives the ALU issue bus and a tag scoreboard. A fixed-latency valid/tag delay line produces

---
 rtl/alu_sched_pkg.sv | 24 ++
 rtl/alu_port_scheduler_if.sv | 30 +++
 rtl/alu_sched_delay_line.sv | 35 +++
 rtl/alu_port_scheduler.sv | 142 ++++++++++++++
 tb/tb_alu_port_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared widths, opcodes and tag helper for the ALU port scheduler, the ALU and its bench.
package alu_sched_pkg;
    localparam int PORTS     = 4;
    localparam int PORT_W    = 2;
    localparam int CMD_W     = 4;
    localparam int TAG_W     = 2;
    localparam int ALU_TAG_W = PORT_W + TAG_W;
    localparam int NUM_TAGS  = 1 << ALU_TAG_W;

    localparam logic [CMD_W-1:0] OP_NOP = 4'h0;
    localparam logic [CMD_W-1:0] OP_ADD = 4'h1;
    localparam logic [CMD_W-1:0] OP_SUB = 4'h2;
    localparam logic [CMD_W-1:0] OP_AND = 4'h3;
    localparam logic [CMD_W-1:0] OP_OR  = 4'h4;
    localparam logic [CMD_W-1:0] OP_XOR = 4'h5;
    localparam logic [CMD_W-1:0] OP_SHL = 4'h6;
    localparam logic [CMD_W-1:0] OP_SHR = 4'h7;

    // ALU tag: port index in the upper bits so the output stage can route by tag[0:1]
    function automatic logic [ALU_TAG_W-1:0] build_tag(input logic [PORT_W-1:0] port,
                                                       input logic [TAG_W-1:0]  tag);
        return {port, tag};
    endfunction
endpackage

// File: rtl/alu_port_scheduler_if.sv
// Request side (four command ports) and ALU issue/completion side of the port scheduler.
interface alu_port_scheduler_if #(parameter int DW = 32);
    import alu_sched_pkg::*;

    logic [0:PORTS-1]                req_vld;
    logic [0:PORTS-1][0:CMD_W-1]     req_cmd;
    logic [0:PORTS-1][0:DW-1]        req_op1;
    logic [0:PORTS-1][0:DW-1]        req_op2;
    logic [0:PORTS-1][0:TAG_W-1]     req_tag;
    logic [0:PORTS-1]                req_rdy;
    logic                            alu_vld;
    logic [0:CMD_W-1]                alu_cmd;
    logic [0:DW-1]                   alu_op1;
    logic [0:DW-1]                   alu_op2;
    logic [0:ALU_TAG_W-1]            alu_tag;
    logic                            prio_alu_out_vld;
    logic [0:ALU_TAG_W-1]            prio_alu_tag;
    logic                            sched_busy;

    modport slave (
        input  req_vld, req_cmd, req_op1, req_op2, req_tag,
        output req_rdy, alu_vld, alu_cmd, alu_op1, alu_op2, alu_tag,
        output prio_alu_out_vld, prio_alu_tag, sched_busy
    );
    modport master (
        output req_vld, req_cmd, req_op1, req_op2, req_tag,
        input  req_rdy, alu_vld, alu_cmd, alu_op1, alu_op2, alu_tag,
        input  prio_alu_out_vld, prio_alu_tag, sched_busy
    );
endinterface

// File: rtl/alu_sched_delay_line.sv
// Fixed-latency {vld,tag} shift register modelling the ALU pipeline depth; no backpressure.
module alu_sched_delay_line
    import alu_sched_pkg::*;
#(
    parameter int ALU_LAT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 vld_i,
    input  logic [ALU_TAG_W-1:0] tag_i,
    output logic                 vld_o,
    output logic [ALU_TAG_W-1:0] tag_o
);
    localparam int STAGES = ALU_LAT - 1;

    logic [STAGES:0]                vld_pipe;
    logic [STAGES:0][ALU_TAG_W-1:0] tag_pipe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= vld_i;
            tag_pipe[0] <= tag_i;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign vld_o = vld_pipe[STAGES];
    assign tag_o = tag_pipe[STAGES];
endmodule

// File: rtl/alu_port_scheduler.sv
// Four-port ALU issue scheduler: one slot per port, tag scoreboard, round-robin pick per cycle.
// ALU_SCHED_STRICT_PRIO_EN selects fixed priority port1 > port4 instead of round-robin.
module alu_port_scheduler
    import alu_sched_pkg::*;
#(
    parameter int ALU_LAT = 3,
    parameter int DW      = 32
) (
    input logic                 c_clk,
    input logic                 reset_n,
    alu_port_scheduler_if.slave sched_if
);
    logic [PORTS-1:0]            slot_full_q;
    logic [PORTS-1:0][CMD_W-1:0] slot_cmd_q;
    logic [PORTS-1:0][DW-1:0]    slot_op1_q, slot_op2_q;
    logic [PORTS-1:0][TAG_W-1:0] slot_tag_q;
    logic [NUM_TAGS-1:0]         busy_q, busy_d;
    logic [PORTS-1:0]            elig, grant, rdy, accept;
    logic                        gnt_any;
    logic [PORT_W-1:0]           gnt_idx, arb_start;
    logic                        alu_vld_q;
    logic [CMD_W-1:0]            alu_cmd_q;
    logic [DW-1:0]               alu_op1_q, alu_op2_q;
    logic [ALU_TAG_W-1:0]        alu_tag_q, issue_tag;
    logic                        cmp_vld;
    logic [ALU_TAG_W-1:0]        cmp_tag;

    // A slot whose tag is still in flight sits out; only its own port stalls
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORTS; i++) begin
            elig[i] = slot_full_q[i] & ~busy_q[build_tag(PORT_W'(i), slot_tag_q[i])];
        end
    end

`ifdef ALU_SCHED_STRICT_PRIO_EN
    assign arb_start = '0;
`else
    logic [PORT_W-1:0] rr_q;
    assign arb_start = rr_q;
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n)     rr_q <= '0;
        else if (gnt_any) rr_q <= gnt_idx + 1'b1;
    end
`endif

    always_comb begin
        logic [PORT_W-1:0] idx;
        idx     = '0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = arb_start + PORT_W'(k);
            if (elig[idx] && !gnt_any) begin
                grant[idx] = 1'b1;
                gnt_any    = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // Interface vectors are ascending (index 0 = port1), so cross them bit by bit
    always_comb begin
        rdy    = '0;
        accept = '0;
        for (int i = 0; i < PORTS; i++) begin
            rdy[i]              = ~slot_full_q[i] | grant[i];
            accept[i]           = sched_if.req_vld[i] & rdy[i];
            sched_if.req_rdy[i] = rdy[i];
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full_q <= '0;
            slot_cmd_q  <= '0;
            slot_op1_q  <= '0;
            slot_op2_q  <= '0;
            slot_tag_q  <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (accept[i]) begin
                    slot_full_q[i] <= 1'b1;
                    slot_cmd_q[i]  <= sched_if.req_cmd[i];
                    slot_op1_q[i]  <= sched_if.req_op1[i];
                    slot_op2_q[i]  <= sched_if.req_op2[i];
                    slot_tag_q[i]  <= sched_if.req_tag[i];
                end else if (grant[i]) begin
                    slot_full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign issue_tag = build_tag(gnt_idx, slot_tag_q[gnt_idx]);

    // Issue last so a completion and a new issue of the same tag leave it busy
    always_comb begin
        busy_d = busy_q;
        if (cmp_vld) busy_d[cmp_tag]   = 1'b0;
        if (gnt_any) busy_d[issue_tag] = 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q    <= '0;
            alu_vld_q <= 1'b0;
            alu_cmd_q <= '0;
            alu_op1_q <= '0;
            alu_op2_q <= '0;
            alu_tag_q <= '0;
        end else begin
            busy_q    <= busy_d;
            alu_vld_q <= gnt_any;
            if (gnt_any) begin
                alu_cmd_q <= slot_cmd_q[gnt_idx];
                alu_op1_q <= slot_op1_q[gnt_idx];
                alu_op2_q <= slot_op2_q[gnt_idx];
                alu_tag_q <= issue_tag;
            end
        end
    end

    alu_sched_delay_line #(.ALU_LAT(ALU_LAT)) u_dly (
        .clk_i  (c_clk),
        .rst_ni (reset_n),
        .vld_i  (alu_vld_q),
        .tag_i  (alu_tag_q),
        .vld_o  (cmp_vld),
        .tag_o  (cmp_tag)
    );

    assign sched_if.alu_vld          = alu_vld_q;
    assign sched_if.alu_cmd          = alu_cmd_q;
    assign sched_if.alu_op1          = alu_op1_q;
    assign sched_if.alu_op2          = alu_op2_q;
    assign sched_if.alu_tag          = alu_tag_q;
    assign sched_if.prio_alu_out_vld = cmp_vld;
    assign sched_if.prio_alu_tag     = cmp_tag;
    assign sched_if.sched_busy       = (|slot_full_q) | (|busy_q);
endmodule

// File: tb/tb_alu_port_scheduler.sv
// Directed bench for alu_port_scheduler: expected issues queued by stimulus, checked by a negedge monitor.
module tb_alu_port_scheduler;
    import alu_sched_pkg::*;

    localparam int LAT = 3;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } cmd_s;

    typedef struct packed {
        logic [3:0]  tag;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } iss_s;

    logic c_clk = 1'b0;
    logic reset_n;
    always #5 c_clk = ~c_clk;

    alu_port_scheduler_if #(.DW(32)) bus ();

    alu_port_scheduler #(.ALU_LAT(LAT), .DW(32)) dut (
        .c_clk    (c_clk),
        .reset_n  (reset_n),
        .sched_if (bus.slave)
    );

    cmd_s       pq [4][$];
    iss_s       exp_iss [$];
    logic [3:0] cmp_tag_q [$];
    int         cmp_cyc_q [$];
    int         iss_log [$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         checks = 0;
    int         failures = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic cmd_s mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] t);
        return {c, a, b, t};
    endfunction

    task automatic add(input int p, input cmd_s c);
        pq[p].push_back(c);
    endtask

    task automatic expect_iss(input int p, input cmd_s c);
        logic [1:0] pi;
        pi = p[1:0];
        exp_iss.push_back({pi, c.tag, c.cmd, c.op1, c.op2});
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            bus.req_vld[p] = 1'b0;
            bus.req_cmd[p] = '0;
            bus.req_op1[p] = '0;
            bus.req_op2[p] = '0;
            bus.req_tag[p] = '0;
        end
    endtask

    // Present each port queue head every cycle; pop it once the slot accepted it
    task automatic run_streams(output int ncyc);
        logic rdy [4];
        ncyc = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) > 0 && ncyc < 60) begin
            for (int p = 0; p < 4; p++) begin
                if (pq[p].size() > 0) begin
                    bus.req_vld[p] = 1'b1;
                    bus.req_cmd[p] = pq[p][0].cmd;
                    bus.req_op1[p] = pq[p][0].op1;
                    bus.req_op2[p] = pq[p][0].op2;
                    bus.req_tag[p] = pq[p][0].tag;
                end else begin
                    bus.req_vld[p] = 1'b0;
                end
            end
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) rdy[p] = bus.req_rdy[p];
            tick();
            ncyc++;
            for (int p = 0; p < 4; p++) begin
                if (pq[p].size() > 0 && rdy[p]) void'(pq[p].pop_front());
            end
        end
        clear_inputs();
        if (ncyc >= 60) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout actual=%0d required<60", ncyc);
        end
    endtask

    always @(negedge c_clk) begin : mon
        iss_s e;
        int   ic;
        if (reset_n) begin
            if (bus.alu_vld) begin
                iss_log.push_back(cyc);
                if (exp_iss.size() == 0) begin
                    check("unexp_issue", bus.alu_vld, 1'b0);
                end else begin
                    e = exp_iss.pop_front();
                    check("issue", {bus.alu_tag, bus.alu_cmd, bus.alu_op1, bus.alu_op2},
                          {e.tag, e.cmd, e.op1, e.op2});
                    cmp_tag_q.push_back(e.tag);
                    cmp_cyc_q.push_back(cyc);
                end
            end
            if (bus.prio_alu_out_vld) begin
                n_cmp++;
                if (cmp_tag_q.size() == 0) begin
                    check("unexp_cmp", bus.prio_alu_out_vld, 1'b0);
                end else begin
                    check("cmp_tag", bus.prio_alu_tag, cmp_tag_q.pop_front());
                    ic = cmp_cyc_q.pop_front();
                    check("cmp_lat", cyc - ic, LAT);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, ncmp0;
        reset_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_rdy", bus.req_rdy, 4'hF);
        check("rst_ctl", {bus.alu_vld, bus.prio_alu_out_vld, bus.sched_busy, bus.alu_cmd,
                          bus.alu_tag, bus.prio_alu_tag}, '0);
        check("rst_ops", {bus.alu_op1, bus.alu_op2}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // T2: single op on port3, accepted at edge k
        add(2, mk(OP_ADD, 32'd5, 32'd7, 2'd2));
        expect_iss(2, mk(OP_ADD, 32'd5, 32'd7, 2'd2));
        run_streams(n);
        check("t2_not_early", bus.alu_vld, 1'b0);
        check("t2_busy", bus.sched_busy, 1'b1);
        tick();
        check("t2_vld", bus.alu_vld, 1'b1);
        check("t2_tag", bus.alu_tag, 4'b1010);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("t2_prio_early", bus.prio_alu_out_vld, 1'b0);
        end
        tick();
        check("t2_prio", {bus.prio_alu_out_vld, bus.prio_alu_tag}, 5'b1_1010);
        tick();
        check("t2_idle", bus.sched_busy, 1'b0);
        repeat (4) tick();

        // T1: reset with two ops in flight
        add(0, mk(OP_AND, 32'h11, 32'h22, 2'd3));
        add(1, mk(OP_OR, 32'h33, 32'h44, 2'd3));
        expect_iss(0, mk(OP_AND, 32'h11, 32'h22, 2'd3));
        expect_iss(1, mk(OP_OR, 32'h33, 32'h44, 2'd3));
        run_streams(n);
        tick();
        tick();
        @(negedge c_clk);
        #1;
        check("t1_inflight", cmp_tag_q.size(), 2);
        reset_n = 1'b0;
        #1;
        check("t1_rdy", bus.req_rdy, 4'hF);
        check("t1_ctl", {bus.alu_vld, bus.prio_alu_out_vld, bus.sched_busy, bus.alu_cmd,
                         bus.alu_tag, bus.prio_alu_tag}, '0);
        check("t1_ops", {bus.alu_op1, bus.alu_op2}, '0);
        cmp_tag_q.delete();
        cmp_cyc_q.delete();
        ncmp0 = n_cmp;
        tick();
        reset_n = 1'b1;
        repeat (LAT + 3) tick();
        check("t1_no_cmp", n_cmp - ncmp0, 0);

`ifndef ALU_SCHED_STRICT_PRIO_EN
        // T3: all ports valid every cycle -> port1,2,3,4,... one grant per cycle
        for (int j = 0; j < 4; j++) begin
            for (int p = 0; p < 4; p++) begin
                add(p, mk(4'(p + 1), 32'(p * 256 + j), 32'(j * 3 + 1), 2'(j)));
                expect_iss(p, mk(4'(p + 1), 32'(p * 256 + j), 32'(j * 3 + 1), 2'(j)));
            end
        end
        base = iss_log.size();
        run_streams(n);
        repeat (8) tick();
        check("t3_count", iss_log.size() - base, 16);
        if (iss_log.size() >= base + 16) check("t3_duty", iss_log[base+15] - iss_log[base], 15);
`endif

        // T4: port2 re-presents a busy tag; port4 keeps issuing
        add(1, mk(OP_SUB, 32'd11, 32'd1, 2'd1));
        add(1, mk(OP_SUB, 32'd22, 32'd2, 2'd1));
        for (int t = 0; t < 4; t++) add(3, mk(OP_XOR, 32'(40 + t), 32'(t), 2'(t)));
        expect_iss(1, mk(OP_SUB, 32'd11, 32'd1, 2'd1));
        for (int t = 0; t < 4; t++) expect_iss(3, mk(OP_XOR, 32'(40 + t), 32'(t), 2'(t)));
        expect_iss(1, mk(OP_SUB, 32'd22, 32'd2, 2'd1));
        base = iss_log.size();
        run_streams(n);
        repeat (10) tick();
        check("t4_count", iss_log.size() - base, 6);
        if (iss_log.size() >= base + 6) check("t4_hold", iss_log[base+5] - iss_log[base], LAT + 2);

        // T5: port1 held valid -> refill on every grant
        for (int t = 0; t < 4; t++) begin
            add(0, mk(OP_SHL, 32'(100 + t), 32'(t), 2'(t)));
            expect_iss(0, mk(OP_SHL, 32'(100 + t), 32'(t), 2'(t)));
        end
        base = iss_log.size();
        run_streams(n);
        check("t5_accept_cycles", n, 4);
        repeat (8) tick();
        check("t5_count", iss_log.size() - base, 4);
        if (iss_log.size() >= base + 4) check("t5_b2b", iss_log[base+3] - iss_log[base], 3);

        // T6: ports 1 and 4 both streaming
        for (int t = 0; t < 3; t++) begin
            add(0, mk(OP_AND, 32'(200 + t), 32'(t), 2'(t)));
            add(3, mk(OP_OR, 32'(300 + t), 32'(t), 2'(t)));
        end
`ifdef ALU_SCHED_STRICT_PRIO_EN
        for (int t = 0; t < 3; t++) expect_iss(0, mk(OP_AND, 32'(200 + t), 32'(t), 2'(t)));
        for (int t = 0; t < 3; t++) expect_iss(3, mk(OP_OR, 32'(300 + t), 32'(t), 2'(t)));
`else
        for (int t = 0; t < 3; t++) begin
            expect_iss(3, mk(OP_OR, 32'(300 + t), 32'(t), 2'(t)));
            expect_iss(0, mk(OP_AND, 32'(200 + t), 32'(t), 2'(t)));
        end
`endif
        base = iss_log.size();
        run_streams(n);
        repeat (10) tick();
        check("t6_count", iss_log.size() - base, 6);

        repeat (LAT + 4) tick();
        check("end_exp_empty", exp_iss.size(), 0);
        check("end_cmp_empty", cmp_tag_q.size(), 0);
        check("end_idle", bus.sched_busy, 1'b0);
        check("end_rdy", bus.req_rdy, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
